// File: rtl/game_state_fsm_pkg.sv
// Shared game types and defaults for game_state_fsm and counter_shapes.
package game_pkg;

   typedef enum logic [2:0] {
      ST_MENU,
      ST_PLAYING,
      ST_HIT,
      ST_WON,
      ST_LOST
   } game_state_t;

   localparam int unsigned LIVES_DEF      = 3;
   localparam int unsigned HIT_CYCLES_DEF = 60;
   localparam logic [10:0] WIN_TIME_DEF   = 11'd1800;
   localparam logic [9:0]  OBJ_WRAP_DEF   = 10'd680;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/button_sync_edge.sv
// Two-flop synchroniser for an asynchronous push-button followed by a
// rising-edge detector; one press yields a single-cycle pulse.
module button_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic btn_i,
   output logic pulse_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= btn_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   // Decoded from flops only, so the pulse is clean for the state register.
   assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/game_state_fsm.sv
// Game controller: menu -> play -> win/lose sequencing, lives with a
// post-hit grace window, and a saturating score of obstacles passed.
module game_state_fsm
   import game_pkg::*;
#(
   parameter int unsigned LIVES      = LIVES_DEF,
   parameter logic [10:0] WIN_TIME   = WIN_TIME_DEF,
   parameter int unsigned HIT_CYCLES = HIT_CYCLES_DEF,
   parameter logic [9:0]  OBJ_WRAP   = OBJ_WRAP_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_btn,
   input  logic        collision,
   input  logic [9:0]  obj_position_counter,
   input  logic [10:0] game_time,
   output logic        menuScreen,
   output logic        playerWon,
   output logic        playerLost,
   output logic        reset_obj_count,
   output logic [1:0]  lives,
   output logic [7:0]  score
);

   localparam int unsigned GW = (HIT_CYCLES > 1) ? $clog2(HIT_CYCLES) : 1;
   localparam logic [GW-1:0] GRACE_LOAD = GW'(HIT_CYCLES - 1);
   localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

   logic start_pulse;

   button_sync_edge u_start_sync (
      .clk     (clk),
      .reset   (reset),
      .btn_i   (start_btn),
      .pulse_o (start_pulse)
   );

   game_state_t   state_q, state_d;
   logic [GW-1:0] grace_q, grace_d;
   logic [1:0]    lives_q, lives_d;
   logic [7:0]    score_q, score_d;
   logic          rst_obj_q, rst_obj_d;
   logic          menu_q, won_q, lost_q;
   logic          hit_acc;
   logic          at_wrap;
   logic          win_reached;

   assign at_wrap     = (obj_position_counter == OBJ_WRAP);
   assign win_reached = (game_time >= WIN_TIME);

   always_comb begin
      state_d   = state_q;
      grace_d   = grace_q;
      lives_d   = lives_q;
      score_d   = score_q;
      rst_obj_d = 1'b0;
      hit_acc   = 1'b0;
      unique case (state_q)
         ST_MENU: begin
            if (start_pulse) begin
               state_d = ST_PLAYING;
               lives_d = LIVES_INIT;
               score_d = '0;
            end
         end
         ST_PLAYING: begin
            if (collision && (lives_q != '0)) begin
               hit_acc   = 1'b1;
               rst_obj_d = 1'b1;
               lives_d   = lives_q - 2'd1;
               if (lives_q == 2'd1) begin
                  state_d = ST_LOST;
               end else begin
                  state_d = ST_HIT;
                  grace_d = GRACE_LOAD;
               end
            end else if (win_reached) begin
               state_d = ST_WON;
            end
            if (at_wrap && !hit_acc) begin
               score_d = sat_inc8(score_q);
            end
         end
         ST_HIT: begin
            // Collisions are not accepted here, so every wrap scores.
            if (at_wrap) begin
               score_d = sat_inc8(score_q);
            end
            if (win_reached) begin
               state_d = ST_WON;
            end else if (grace_q == '0) begin
               state_d = ST_PLAYING;
            end else begin
               grace_d = grace_q - 1'b1;
            end
         end
         ST_WON, ST_LOST: begin
            if (start_pulse) begin
               state_d = ST_MENU;
            end
         end
         default: state_d = ST_MENU;
      endcase
   end

   // Flags are decoded from the next state so they land with the state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_MENU;
         grace_q   <= '0;
         lives_q   <= LIVES_INIT;
         score_q   <= '0;
         rst_obj_q <= 1'b0;
         menu_q    <= 1'b1;
         won_q     <= 1'b0;
         lost_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         grace_q   <= grace_d;
         lives_q   <= lives_d;
         score_q   <= score_d;
         rst_obj_q <= rst_obj_d;
         menu_q    <= (state_d == ST_MENU);
         won_q     <= (state_d == ST_WON);
         lost_q    <= (state_d == ST_LOST);
      end
   end

   assign menuScreen      = menu_q;
   assign playerWon       = won_q;
   assign playerLost      = lost_q;
   assign reset_obj_count = rst_obj_q;
   assign lives           = lives_q;
   assign score           = score_q;

endmodule

// File: tb/tb_game_state_fsm.sv
// Randomised scenario bench for game_state_fsm against a cycle-level
// reference model of the game rules.
module tb_game_state_fsm;

   localparam int LIVES_P = 3;
   localparam int HIT_P   = 60;
   localparam int WIN_P   = 1800;
   localparam int WRAP_P  = 680;

   localparam int M_MENU = 0;
   localparam int M_PLAY = 1;
   localparam int M_HIT  = 2;
   localparam int M_WON  = 3;
   localparam int M_LOST = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_btn;
   logic        collision;
   logic [9:0]  pos;
   logic [10:0] gt;
   logic        menuScreen, playerWon, playerLost, reset_obj_count;
   logic [1:0]  lives;
   logic [7:0]  score;

   int n_vec = 0;
   int n_err = 0;

   int m_mode, m_lives, m_score, m_grace;
   bit m_rst;
   bit h1, h2, h3;

   game_state_fsm #(
      .LIVES      (LIVES_P),
      .WIN_TIME   (11'd1800),
      .HIT_CYCLES (HIT_P),
      .OBJ_WRAP   (10'd680)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .start_btn            (start_btn),
      .collision            (collision),
      .obj_position_counter (pos),
      .game_time            (gt),
      .menuScreen           (menuScreen),
      .playerWon            (playerWon),
      .playerLost           (playerLost),
      .reset_obj_count      (reset_obj_count),
      .lives                (lives),
      .score                (score)
   );

   always #5 clk = ~clk;

   function automatic logic [13:0] dut_v();
      return {menuScreen, playerWon, playerLost, reset_obj_count, lives, score};
   endfunction

   function automatic logic [13:0] mdl_v();
      return {m_mode == M_MENU, m_mode == M_WON, m_mode == M_LOST, m_rst,
              2'(m_lives), 8'(m_score)};
   endfunction

   task automatic model_reset();
      m_mode  = M_MENU;
      m_lives = LIVES_P;
      m_score = 0;
      m_grace = 0;
      m_rst   = 1'b0;
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
   endtask

   // One clock of game rules; the press is seen two samples late, once.
   task automatic model_step();
      bit press;
      bit wrap;
      press = h2 && !h3;
      h3 = h2; h2 = h1; h1 = start_btn;
      wrap  = (int'(pos) == WRAP_P);
      m_rst = 1'b0;
      case (m_mode)
         M_MENU: if (press) begin m_mode = M_PLAY; m_lives = LIVES_P; m_score = 0; end
         M_PLAY: begin
            if (collision) begin
               m_rst = 1'b1;
               m_mode = (m_lives == 1) ? M_LOST : M_HIT;
               m_lives = m_lives - 1;
               m_grace = HIT_P - 1;
            end else begin
               if (int'(gt) >= WIN_P) m_mode = M_WON;
               if (wrap && m_score < 255) m_score++;
            end
         end
         M_HIT: begin
            if (wrap && m_score < 255) m_score++;
            if (int'(gt) >= WIN_P) m_mode = M_WON;
            else if (m_grace == 0) m_mode = M_PLAY;
            else m_grace--;
         end
         default: if (press) m_mode = M_MENU;
      endcase
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      start_btn = 1'b0; collision = 1'b0; pos = '0; gt = '0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic press();
      start_btn = 1'b1;
      repeat (4) step();
      start_btn = 1'b0;
      repeat (4) step();
   endtask

   function automatic logic [9:0] rand_pos();
      return ($urandom_range(0, 9) == 0) ? 10'd680 : 10'(($urandom_range(0, 679)));
   endfunction

   task automatic test_reset();
      do_reset();
      n_vec++;
      if (dut_v() !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 8'd0}) begin
         n_err++;
         $display("FAIL reset_state: got %h want %h", dut_v(), {1'b1, 3'b000, 2'd3, 8'd0});
      end
   endtask

   task automatic test_start();
      int falls;
      logic prev_menu;
      falls = 0;
      prev_menu = menuScreen;
      start_btn = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         if (i == 11) start_btn = 1'b0;
         step();
         n_vec++;
         if (dut_v() !== mdl_v()) begin
            n_err++;
            $display("FAIL start cyc %0d: got %h want %h", i, dut_v(), mdl_v());
         end
         n_vec++;
         if (menuScreen !== (i < 3)) begin
            n_err++;
            $display("FAIL start_latency cyc %0d: got menuScreen=%b want %b", i, menuScreen, i < 3);
         end
         if (prev_menu && !menuScreen) falls++;
         prev_menu = menuScreen;
      end
      n_vec++;
      if (falls != 1 || score !== 8'd0) begin
         n_err++;
         $display("FAIL start_once: got falls=%0d score=%0d want 1 and 0", falls, score);
      end
   endtask

   task automatic test_hits();
      do_reset();
      press();
      for (int k = 0; k < 3; k++) begin
         int gap;
         gap = $urandom_range(HIT_P + 10, HIT_P + 60);
         for (int i = 0; i < gap; i++) begin
            pos = rand_pos();
            step();
            n_vec++;
            if (dut_v() !== mdl_v()) begin
               n_err++;
               $display("FAIL hits_gap hit %0d cyc %0d: got %h want %h", k, i, dut_v(), mdl_v());
            end
         end
         collision = 1'b1;
         pos = rand_pos();
         step();
         collision = 1'b0;
         n_vec++;
         if (reset_obj_count !== 1'b1 || lives !== 2'(2 - k) || dut_v() !== mdl_v()) begin
            n_err++;
            $display("FAIL hits_take hit %0d: got rst=%b lives=%0d vec %h want rst=1 lives=%0d vec %h",
                     k, reset_obj_count, lives, dut_v(), 2 - k, mdl_v());
         end
         step();
         n_vec++;
         if (reset_obj_count !== 1'b0) begin
            n_err++;
            $display("FAIL hits_pulse_width hit %0d: got rst=%b want 0", k, reset_obj_count);
         end
      end
      n_vec++;
      if (playerLost !== 1'b1) begin
         n_err++;
         $display("FAIL hits_lost: got playerLost=%b want 1", playerLost);
      end
   endtask

   task automatic test_grace();
      int hits[$];
      do_reset();
      press();
      collision = 1'b1;
      for (int i = 0; i < 200; i++) begin
         step();
         if (reset_obj_count === 1'b1) hits.push_back(i);
         n_vec++;
         if (dut_v() !== mdl_v()) begin
            n_err++;
            $display("FAIL grace cyc %0d: got %h want %h", i, dut_v(), mdl_v());
         end
      end
      collision = 1'b0;
      n_vec++;
      if (hits.size() != 3 || hits[0] != 0 || hits[1] != 61 || hits[2] != 122 || playerLost !== 1'b1) begin
         n_err++;
         $display("FAIL grace_hits: got %0d hits (%p) lost=%b want hits at 0,61,122 lost=1",
                  hits.size(), hits, playerLost);
      end
   endtask

   task automatic test_win();
      int t;
      int frozen;
      do_reset();
      press();
      t = 0;
      while (t < WIN_P) begin
         gt = 11'(t);
         pos = rand_pos();
         step();
         n_vec++;
         if (dut_v() !== mdl_v() || playerWon !== 1'b0) begin
            n_err++;
            $display("FAIL win_ramp t=%0d: got %h want %h", t, dut_v(), mdl_v());
         end
         t += $urandom_range(1, 40);
      end
      gt = 11'd1800;
      pos = rand_pos();
      step();
      frozen = m_score;
      n_vec++;
      if (playerWon !== 1'b1 || dut_v() !== mdl_v()) begin
         n_err++;
         $display("FAIL win_flag: got won=%b vec %h want won=1 vec %h", playerWon, dut_v(), mdl_v());
      end
      for (int i = 0; i < 20; i++) begin
         pos = (i % 2 == 0) ? 10'd680 : 10'd3;
         collision = (i == 7);
         step();
         n_vec++;
         if (score !== 8'(frozen) || lives !== 2'd3 || playerWon !== 1'b1) begin
            n_err++;
            $display("FAIL win_frozen cyc %0d: got score=%0d lives=%0d won=%b want %0d 3 1",
                     i, score, lives, playerWon, frozen);
         end
      end
      collision = 1'b0;
      press();
      n_vec++;
      if (menuScreen !== 1'b1 || score !== 8'(frozen) || dut_v() !== mdl_v()) begin
         n_err++;
         $display("FAIL win_to_menu: got menu=%b score=%0d want menu=1 score=%0d", menuScreen, score, frozen);
      end
   endtask

   task automatic test_score();
      do_reset();
      press();
      for (int p = 0; p < WRAP_P; p += 5) begin pos = 10'(p); step(); end
      pos = 10'd680;
      collision = 1'b1;
      step();
      collision = 1'b0;
      n_vec++;
      if (score !== 8'd0 || lives !== 2'd2 || dut_v() !== mdl_v()) begin
         n_err++;
         $display("FAIL score_collide_wrap: got score=%0d lives=%0d want 0 2", score, lives);
      end
      for (int w = 0; w < 300; w++) begin
         for (int p = 0; p <= WRAP_P; p += 5) begin
            pos = 10'(p);
            step();
            n_vec++;
            if (dut_v() !== mdl_v()) begin
               n_err++;
               $display("FAIL score wrap %0d pos %0d: got %h want %h", w, p, dut_v(), mdl_v());
            end
         end
      end
      n_vec++;
      if (score !== 8'd255) begin
         n_err++;
         $display("FAIL score_saturate: got %0d want 255", score);
      end
   endtask

   task automatic test_same_cycle();
      do_reset();
      press();
      for (int k = 0; k < 2; k++) begin
         collision = 1'b1;
         step();
         collision = 1'b0;
         repeat (HIT_P + 5) step();
      end
      n_vec++;
      if (lives !== 2'd1 || dut_v() !== mdl_v()) begin
         n_err++;
         $display("FAIL same_setup: got lives=%0d vec %h want lives=1 vec %h", lives, dut_v(), mdl_v());
      end
      collision = 1'b1;
      gt = 11'd1800;
      step();
      collision = 1'b0;
      n_vec++;
      if (playerLost !== 1'b1 || playerWon !== 1'b0 || lives !== 2'd0) begin
         n_err++;
         $display("FAIL same_cycle_lost: got lost=%b won=%b lives=%0d want 1 0 0",
                  playerLost, playerWon, lives);
      end
      gt = '0;
   endtask

   task automatic test_async_reset();
      do_reset();
      press();
      collision = 1'b1;
      step();
      collision = 1'b0;
      repeat (5) step();
      n_vec++;
      if (lives !== 2'd2 || dut_v() !== mdl_v()) begin
         n_err++;
         $display("FAIL areset_setup: got %h want %h", dut_v(), mdl_v());
      end
      #2 reset = 1'b1;
      #1;
      n_vec++;
      if (menuScreen !== 1'b1 || lives !== 2'd3 || score !== 8'd0 || playerLost !== 1'b0) begin
         n_err++;
         $display("FAIL areset_immediate: got menu=%b lives=%0d score=%0d want 1 3 0",
                  menuScreen, lives, score);
      end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      reset = 1'b1;
      start_btn = 1'b0; collision = 1'b0; pos = '0; gt = '0;
      model_reset();
      test_reset();
      test_start();
      test_hits();
      test_grace();
      test_win();
      test_score();
      test_same_cycle();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1);
   end

endmodule
